cpu_core: RTL

//  Parametrised multicycle CPU core: next generation of the 8-bit cpu.

---
 rtl/cpu_core_if.sv | 15 +
 rtl/cpu_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_if.sv
// Memory request/acknowledge channel: cpu_core drives the master side, memory the slave side.
interface cpu_core_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/cpu_core.sv
// Multicycle CPU core: FETCH/DECODE/IMM/EXEC/MEM/HALT sequencer, 7 GPRs, Z/C flags, req/ack memory.
// Define CPU_CALL_STACK_EN to enable CALL/RET with a STK_DEPTH-entry return stack and fault reporting.
module cpu_core #(
    parameter int            DW        = 8,
    parameter int            AW        = 8,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int            STK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    cpu_core_if.master    mem,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          halted,
    output logic          fault
);
    if (DW < 8 || AW > DW || STK_DEPTH < 1) begin : g_param_check
        $error("cpu_core: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_IMM, S_EXEC, S_MEM, S_HALT} state_e;

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] ir_q, t_q;
    logic [DW-1:0] rf_q [8];     // entry 7 is never written; index 7 selects memory/immediate
    logic          z_q, c_q;
    logic [DW-1:0] out_data_q;
    logic          out_valid_q, halted_q, fault_q;

    // Instruction decode
    logic [7:0] op;
    logic [2:0] f_d, f_s;
    logic       is_ldi, is_out, is_hlt, is_mov, mov_mem, is_alu, alu_imm, is_jcc;
    logic       is_call, is_ret, two_word, jcc_taken;

    assign op      = ir_q[7:0];
    assign f_d     = op[5:3];
    assign f_s     = op[2:0];
    assign is_ldi  = (op[7:3] == 5'b00010) && (f_s != 3'd7);
    assign is_out  = (op[7:3] == 5'b00011) && (f_s != 3'd7);
    assign is_hlt  = (op == 8'h7F);
    assign is_mov  = (op[7:6] == 2'b01) && !is_hlt;
    assign mov_mem = is_mov && ((f_d == 3'd7) || (f_s == 3'd7));
    assign is_alu  = (op[7:6] == 2'b10);
    assign alu_imm = is_alu && (f_s == 3'd7);
    assign is_jcc  = (op[7:3] == 5'b11000) && (f_s <= 3'd4);
`ifdef CPU_CALL_STACK_EN
    assign is_call = (op == 8'hC8);
    assign is_ret  = (op == 8'hD0);
`else
    assign is_call = 1'b0;
    assign is_ret  = 1'b0;
`endif
    assign two_word = is_ldi | mov_mem | alu_imm | is_jcc | is_call;

    always_comb begin
        jcc_taken = 1'b0;
        case (f_s)
            3'd0:    jcc_taken = 1'b1;
            3'd1:    jcc_taken = z_q;
            3'd2:    jcc_taken = !z_q;
            3'd3:    jcc_taken = c_q;
            3'd4:    jcc_taken = !c_q;
            default: jcc_taken = 1'b0;
        endcase
    end

    // ALU: alu_r[DW] is the carry/borrow/shifted-out bit
    logic [DW-1:0] alu_b;
    logic [DW:0]   alu_r;

    always_comb begin
        alu_b = alu_imm ? t_q : rf_q[f_s];
        alu_r = '0;
        case (f_d)
            3'd0:    alu_r = {1'b0, rf_q[0]} + {1'b0, alu_b};
            3'd1:    alu_r = {1'b0, rf_q[0]} - {1'b0, alu_b};
            3'd2:    alu_r = {1'b0, rf_q[0] & alu_b};
            3'd3:    alu_r = {1'b0, rf_q[0] | alu_b};
            3'd4:    alu_r = {1'b0, rf_q[0] ^ alu_b};
            3'd5:    alu_r = {1'b0, ~rf_q[0]};
            3'd6:    alu_r = {rf_q[0], 1'b0};
            default: alu_r = {rf_q[0][0], 1'b0, rf_q[0][DW-1:1]};
        endcase
    end

`ifdef CPU_CALL_STACK_EN
    localparam int SPW = $clog2(STK_DEPTH + 1);
    localparam int IW  = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
    logic [AW-1:0]  stk_q [STK_DEPTH];
    logic [SPW-1:0] sp_q, sp_m1;
    logic           stk_full, stk_empty;
    assign sp_m1     = sp_q - SPW'(1);
    assign stk_full  = (sp_q == SPW'(STK_DEPTH));
    assign stk_empty = (sp_q == '0);
`endif

    // Request is combinational so 0-wait acks complete in the request cycle
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = pc_q;
        mem.mem_wdata = rf_q[f_s];
        case (state_q)
            S_FETCH, S_IMM: mem.mem_req = 1'b1;
            S_MEM: begin
                mem.mem_req  = 1'b1;
                mem.mem_we   = (f_d == 3'd7);
                mem.mem_addr = t_q[AW-1:0];
            end
            default: mem.mem_req = 1'b0;
        endcase
        if (reset) mem.mem_req = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_VEC;
            ir_q        <= '0;
            t_q         <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
`ifdef CPU_CALL_STACK_EN
            sp_q        <= '0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_FETCH: if (mem.mem_ack) begin
                    ir_q    <= mem.mem_rdata;
                    pc_q    <= pc_q + 1'b1;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    state_q <= S_FETCH;
                    if (is_hlt) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (two_word) begin
                        state_q <= S_IMM;
                    end else if (is_mov) begin
                        rf_q[f_d] <= rf_q[f_s];
                    end else if (is_alu) begin
                        rf_q[0] <= alu_r[DW-1:0];
                        z_q     <= (alu_r[DW-1:0] == '0);
                        c_q     <= alu_r[DW];
                    end else if (is_out) begin
                        out_data_q  <= rf_q[f_s];
                        out_valid_q <= 1'b1;
                    end
`ifdef CPU_CALL_STACK_EN
                    else if (is_ret) begin
                        if (stk_empty) begin
                            fault_q  <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            pc_q <= stk_q[IW'(sp_m1)];
                            sp_q <= sp_m1;
                        end
                    end
`endif
                end
                S_IMM: if (mem.mem_ack) begin
                    t_q     <= mem.mem_rdata;
                    pc_q    <= pc_q + 1'b1;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    if (is_ldi) begin
                        rf_q[f_s] <= t_q;
                    end else if (alu_imm) begin
                        rf_q[0] <= alu_r[DW-1:0];
                        z_q     <= (alu_r[DW-1:0] == '0);
                        c_q     <= alu_r[DW];
                    end else if (is_jcc) begin
                        if (jcc_taken) pc_q <= t_q[AW-1:0];
                    end else if (mov_mem) begin
                        state_q <= S_MEM;
                    end
`ifdef CPU_CALL_STACK_EN
                    else if (is_call) begin
                        if (stk_full) begin
                            fault_q  <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            stk_q[IW'(sp_q)] <= pc_q;
                            sp_q             <= sp_q + SPW'(1);
                            pc_q             <= t_q[AW-1:0];
                        end
                    end
`endif
                end
                S_MEM: if (mem.mem_ack) begin
                    if (f_s == 3'd7) rf_q[f_d] <= mem.mem_rdata;
                    state_q <= S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
endmodule
